// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, instruction field positions and issuer state encoding for alu_issuer
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA1 = 4'b1001;
  localparam logic [3:0] OP_ROL1 = 4'b1010;
  localparam logic [3:0] OP_ROR1 = 4'b1011;
  localparam logic [3:0] OP_EQ   = 4'b1100;
  localparam int CTRL_LSB = 12;
  localparam int RD_LSB   = 9;
  localparam int RS_LSB   = 6;
  localparam int RT_LSB   = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/alu_issuer_regfile.sv
// alu_issuer_regfile: NREG x DATA_W regs, writeback port beats load port on same address; ports we/wa/wd, ld_en/ld_addr/ld_data, comb reads ra/rb/dbg
module alu_issuer_regfile #(
  parameter int NREG   = 8,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic              ld_en_i,
  input  logic [AW-1:0]     ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic [AW-1:0]     ra_i,
  input  logic [AW-1:0]     rb_i,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  output logic [DATA_W-1:0] rb_data_o,
  output logic [DATA_W-1:0] dbg_data_o
);
  logic [DATA_W-1:0] mem_q [NREG];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we_i && wa_i == AW'(i)) mem_q[i] <= wd_i;
        else if (ld_en_i && ld_addr_i == AW'(i)) mem_q[i] <= ld_data_i;
      end
    end
  end
  assign ra_data_o  = mem_q[ra_i];
  assign rb_data_o  = mem_q[rb_i];
  assign dbg_data_o = mem_q[dbg_addr_i];
endmodule

// File: rtl/alu_issuer.sv
// alu_issuer: IDLE->EXEC->DONE issuer driving an external ALU (alu_ctrl/x/y out, alu_out/carry in) from a regfile, with instr valid/ready, load, debug and res_* ports; ALU_ISSUER_FLAGS_EN adds flag_z_o/flag_c_o
module alu_issuer import alu_pkg::*; #(
  parameter int NREG   = 8,
  parameter int DATA_W = 8,
  parameter int CTRL_W = 4,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic [15:0]       instr_i,
  input  logic              ld_en_i,
  input  logic [AW-1:0]     ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic [DATA_W-1:0] alu_x_o,
  output logic [DATA_W-1:0] alu_y_o,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic              alu_carry_i,
  output logic              res_valid_o,
  output logic [AW-1:0]     res_rd_o,
  output logic [DATA_W-1:0] res_data_o,
  output logic              res_carry_o
`ifdef ALU_ISSUER_FLAGS_EN
  ,
  output logic              flag_z_o,
  output logic              flag_c_o
`endif
);
  state_e state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d, data_q, data_d, rs_data, rt_data;
  logic [AW-1:0] rd_q, rd_d;
  logic carry_q, carry_d, accept, wb, unused_bits;
  assign unused_bits = ^instr_i[2:0];
  assign accept = instr_valid_i && state_q == IDLE;
  assign wb = state_q == EXEC;
  alu_issuer_regfile #(.NREG(NREG), .DATA_W(DATA_W), .AW(AW)) u_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (wb),
    .wa_i       (rd_q),
    .wd_i       (alu_out_i),
    .ld_en_i    (ld_en_i),
    .ld_addr_i  (ld_addr_i),
    .ld_data_i  (ld_data_i),
    .ra_i       (instr_i[RS_LSB +: AW]),
    .rb_i       (instr_i[RT_LSB +: AW]),
    .dbg_addr_i (dbg_addr_i),
    .ra_data_o  (rs_data),
    .rb_data_o  (rt_data),
    .dbg_data_o (dbg_data_o)
  );
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = instr_valid_i ? EXEC : IDLE;
      EXEC:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    ctrl_d  = accept ? instr_i[CTRL_LSB +: CTRL_W] : ctrl_q;
    x_d     = accept ? rs_data : x_q;
    y_d     = accept ? rt_data : y_q;
    rd_d    = accept ? instr_i[RD_LSB +: AW] : rd_q;
    data_d  = wb ? alu_out_i : data_q;
    carry_d = wb ? alu_carry_i : carry_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      carry_q <= carry_d;
    end
  end
  assign instr_ready_o = state_q == IDLE;
  assign res_valid_o   = state_q == DONE;
  assign alu_ctrl_o    = ctrl_q;
  assign alu_x_o       = x_q;
  assign alu_y_o       = y_q;
  assign res_rd_o      = rd_q;
  assign res_data_o    = data_q;
  assign res_carry_o   = carry_q;
`ifdef ALU_ISSUER_FLAGS_EN
  logic fz_q, fc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fz_q <= 1'b0;
      fc_q <= 1'b0;
    end else begin
      fz_q <= wb ? alu_out_i == '0 : fz_q;
      fc_q <= wb ? alu_carry_i : fc_q;
    end
  end
  assign flag_z_o = fz_q;
  assign flag_c_o = fc_q;
`endif
endmodule

// File: tb/tb_alu_issuer.sv
// tb_alu_issuer: directed plus random instructions checked against a register-array reference model
module tb_alu_issuer;
  logic clk = 0, rst_n = 0, instr_valid_i = 0, ld_en_i = 0;
  logic [15:0] instr_i = '0;
  logic [2:0] ld_addr_i = '0, dbg_addr_i = '0, res_rd_o;
  logic [7:0] ld_data_i = '0, dbg_data_o, alu_x_o, alu_y_o, alu_out_i, res_data_o;
  logic [3:0] alu_ctrl_o;
  logic instr_ready_o, alu_carry_i, res_valid_o, res_carry_o;
  logic [8:0] alu_res;
`ifdef ALU_ISSUER_FLAGS_EN
  logic flag_z_o, flag_c_o;
`endif
  logic [7:0] model [8];
  logic exp_z = 0, exp_c = 0;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  alu_issuer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .ld_en_i(ld_en_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i),
    .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_x_o(alu_x_o), .alu_y_o(alu_y_o), .alu_out_i(alu_out_i), .alu_carry_i(alu_carry_i),
    .res_valid_o(res_valid_o), .res_rd_o(res_rd_o), .res_data_o(res_data_o), .res_carry_o(res_carry_o)
`ifdef ALU_ISSUER_FLAGS_EN
    , .flag_z_o(flag_z_o), .flag_c_o(flag_c_o)
`endif
  );

  // {carry, out} of the 8-bit ALU; add/sub are 9-bit sign-extended with carry = bit 8
  function automatic logic [8:0] alu_ref(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
    logic [8:0] sx, sy;
    sx = {x[7], x};
    sy = {y[7], y};
    case (c)
      4'd0:  return sx + sy;
      4'd1:  return sx - sy;
      4'd2:  return {1'b0, x & y};
      4'd3:  return {1'b0, x | y};
      4'd4:  return {1'b0, ~x};
      4'd5:  return {1'b0, x ^ y};
      4'd6:  return {1'b0, ~(x | y)};
      4'd7:  return {1'b0, x[6:0], 1'b0};
      4'd8:  return {2'b0, x[7:1]};
      4'd9:  return {1'b0, x[7], x[7:1]};
      4'd10: return {1'b0, x[6:0], x[7]};
      4'd11: return {1'b0, x[0], x[7:1]};
      4'd12: return {8'b0, x == y};
      default: return 9'd0;
    endcase
  endfunction

  assign alu_res     = alu_ref(alu_ctrl_o, alu_x_o, alu_y_o);
  assign alu_out_i   = alu_res[7:0];
  assign alu_carry_i = alu_res[8];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input logic [2:0] a);
    dbg_addr_i = a;
    #1;
    check("dbg_reg", {5'd0, a, dbg_data_o}, {5'd0, a, model[a]});
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    ld_en_i = 1; ld_addr_i = a; ld_data_i = d;
    @(negedge clk);
    ld_en_i = 0;
    model[a] = d;
  endtask

  // Issue one instruction from IDLE; optional load on the accept edge (la) and on the writeback edge (lb)
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt,
                       input bit la_en, input logic [2:0] la, input logic [7:0] la_d,
                       input bit lb_en, input logic [2:0] lb, input logic [7:0] lb_d);
    logic [7:0] xv, yv;
    logic [8:0] r;
    xv = model[rs];
    yv = model[rt];
    r = alu_ref(op, xv, yv);
    check("ready_idle", instr_ready_o, 1);
    instr_valid_i = 1;
    instr_i = {op, rd, rs, rt, 3'($urandom)};
    ld_en_i = la_en; ld_addr_i = la; ld_data_i = la_d;
    @(negedge clk);
    if (la_en) model[la] = la_d;
    instr_valid_i = 1'($urandom);
    instr_i = 16'($urandom);
    ld_en_i = lb_en; ld_addr_i = lb; ld_data_i = lb_d;
    check("ready_exec", instr_ready_o, 0);
    check("valid_exec", res_valid_o, 0);
    check("alu_ctrl", alu_ctrl_o, op);
    check("alu_x", alu_x_o, xv);
    check("alu_y", alu_y_o, yv);
    @(negedge clk);
    model[rd] = r[7:0];
    if (lb_en && lb != rd) model[lb] = lb_d;
    exp_z = r[7:0] == 0;
    exp_c = r[8];
    instr_valid_i = 0;
    ld_en_i = 0;
    check("valid_done", res_valid_o, 1);
    check("res_rd", res_rd_o, rd);
    check("res_data", res_data_o, r[7:0]);
    check("res_carry", res_carry_o, r[8]);
`ifdef ALU_ISSUER_FLAGS_EN
    check("flag_z", flag_z_o, exp_z);
    check("flag_c", flag_c_o, exp_c);
`endif
    check_reg(rd);
    if (lb_en) check_reg(lb);
    if (la_en) check_reg(la);
    @(negedge clk);
    check("valid_pulse_end", res_valid_o, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", instr_ready_o, 1);
    check("rst_valid", res_valid_o, 0);
    check("rst_alu", {alu_ctrl_o, alu_x_o}, 0);
    check("rst_alu_y", alu_y_o, 0);
    check("rst_res", {res_rd_o, res_carry_o, res_data_o}, 0);
    for (int i = 0; i < 8; i++) check_reg(3'(i));
    rst_n = 1;
    @(negedge clk);
    // ADD positive overflow into bit 7, carry stays 0
    load(3'd1, 8'h7F);
    load(3'd2, 8'h01);
    issue(4'd0, 3'd3, 3'd1, 3'd2, 0, 0, 0, 0, 0, 0);
    // ADD of two negatives: result 0, carry 1
    load(3'd1, 8'h80);
    load(3'd2, 8'h80);
    issue(4'd0, 3'd4, 3'd1, 3'd2, 0, 0, 0, 0, 0, 0);
    // Back-to-back with valid held high: SUB r5 then XOR r6,r5,r5
    instr_valid_i = 1;
    instr_i = {4'd1, 3'd5, 3'd1, 3'd2, 3'd0};
    @(negedge clk);
    instr_i = {4'd5, 3'd6, 3'd5, 3'd5, 3'd0};
    check("b2b_ctrl1", alu_ctrl_o, 1);
    @(negedge clk);
    model[5] = alu_ref(4'd1, model[1], model[2]);
    check("b2b_valid1", res_valid_o, 1);
    check("b2b_data1", res_data_o, model[5]);
    @(negedge clk);
    check("b2b_ready", instr_ready_o, 1);
    @(negedge clk);
    instr_valid_i = 0;
    check("b2b_ctrl2", alu_ctrl_o, 5);
    check("b2b_x2", alu_x_o, model[5]);
    @(negedge clk);
    model[6] = 8'h00;
    check("b2b_valid2", res_valid_o, 1);
    check("b2b_data2", res_data_o, 8'h00);
    check_reg(3'd6);
    @(negedge clk);
    // Unused opcode writes 0 with carry 0
    load(3'd1, 8'h55);
    issue(4'hF, 3'd7, 3'd1, 3'd1, 0, 0, 0, 0, 0, 0);
    // Writeback beats a load to the same register
    load(3'd1, 8'h0F);
    load(3'd2, 8'hFF);
    issue(4'd2, 3'd3, 3'd1, 3'd2, 0, 0, 0, 1, 3'd3, 8'hAA);
    // Load to another register on the writeback edge lands too
    issue(4'd3, 3'd4, 3'd1, 3'd3, 0, 0, 0, 1, 3'd2, 8'h3C);
    // Load on the accept edge: operand sees the pre-load value
    issue(4'd0, 3'd5, 3'd2, 3'd1, 1, 3'd2, 8'h11, 0, 0, 0);
    // Reset mid-EXEC aborts the instruction
    load(3'd6, 8'h22);
    instr_valid_i = 1;
    instr_i = {4'd0, 3'd6, 3'd1, 3'd2, 3'd0};
    @(negedge clk);
    instr_valid_i = 0;
    check("abort_exec", instr_ready_o, 0);
    rst_n = 0;
    #1;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    exp_z = 0;
    exp_c = 0;
    check("abort_ready", instr_ready_o, 1);
    check("abort_valid", res_valid_o, 0);
    check_reg(3'd6);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_pulse", res_valid_o, 0);
      check("abort_ready_after", instr_ready_o, 1);
    end
    check_reg(3'd6);
`ifdef ALU_ISSUER_FLAGS_EN
    check("abort_flag_z", flag_z_o, 0);
    check("abort_flag_c", flag_c_o, 0);
`endif
    // Random instructions, loads and collisions
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) load(3'($urandom), 8'($urandom));
      issue(4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
            $urandom_range(0, 3) == 0, 3'($urandom), 8'($urandom),
            $urandom_range(0, 3) == 0, 3'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    for (int i = 0; i < 8; i++) check_reg(3'(i));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
